// File: rtl/ppi_arbiter_pkg.sv
// Shared types and constants for the two-requester PPI access arbiter.
package ppi_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_ACK    = 3'd5
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_AUX = 1'b1
  } req_id_e;

  localparam logic [1:0] PPI_A    = 2'd0;
  localparam logic [1:0] PPI_B    = 2'd1;
  localparam logic [1:0] PPI_C    = 2'd2;
  localparam logic [1:0] PPI_CTRL = 2'd3;

endpackage

// File: rtl/ppi_arbiter_if.sv
// Requester-side access port of ppi_arbiter; PPI_ARBITER_LOCK_EN adds the lock bit.
// Handshake: req is a level held (with we/addr/wdata/lock stable) until a one-cycle ack;
// rdata is valid from the ack cycle until that requester's next ack.
interface ppi_arbiter_if;
  logic       req;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rdata;
`ifdef PPI_ARBITER_LOCK_EN
  logic       lock;

  modport master (output req, we, addr, wdata, lock, input ack, rdata);
  modport slave  (input req, we, addr, wdata, lock, output ack, rdata);
`else
  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
`endif
endinterface

// File: rtl/ppi_arbiter_pick.sv
// Grant selection with starvation counter; PPI_ARBITER_LOCK_EN adds bus locking.
module ppi_arbiter_pick
  import ppi_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    cpu_req_i,
  input  logic    aux_req_i,
`ifdef PPI_ARBITER_LOCK_EN
  input  logic    cpu_lock_i,
  input  logic    aux_lock_i,
  input  logic    done_i,
`endif
  input  logic    take_i,
  output logic    grant_valid_o,
  output req_id_e grant_id_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic       locked;

`ifdef PPI_ARBITER_LOCK_EN
  logic    lock_act_q, lock_act_d;
  logic    lock_pend_q, lock_pend_d;
  req_id_e owner_q, owner_d;
  req_id_e pend_owner_q, pend_owner_d;

  assign locked = lock_act_q;
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    grant_valid_o = cpu_req_i | aux_req_i;
    grant_id_o    = (aux_req_i && (!cpu_req_i || starve_q == LIMIT)) ? REQ_AUX : REQ_CPU;
`ifdef PPI_ARBITER_LOCK_EN
    // A held lock excludes the other requester entirely, even if the owner is idle.
    if (lock_act_q) begin
      grant_valid_o = (owner_q == REQ_AUX) ? aux_req_i : cpu_req_i;
      grant_id_o    = owner_q;
    end
`endif
  end

  always_comb begin
    starve_d = starve_q;
    if (take_i && grant_valid_o && !locked) begin
      if (grant_id_o == REQ_AUX)
        starve_d = '0;
      else if (aux_req_i && starve_q < LIMIT)
        starve_d = starve_q + 4'd1;
    end
  end

`ifdef PPI_ARBITER_LOCK_EN
  always_comb begin
    lock_act_d   = lock_act_q;
    lock_pend_d  = lock_pend_q;
    owner_d      = owner_q;
    pend_owner_d = pend_owner_q;
    if (take_i && grant_valid_o) begin
      pend_owner_d = grant_id_o;
      lock_pend_d  = (grant_id_o == REQ_AUX) ? aux_lock_i : cpu_lock_i;
    end
    if (done_i) begin
      lock_act_d = lock_pend_q;
      owner_d    = pend_owner_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_act_q   <= 1'b0;
      lock_pend_q  <= 1'b0;
      owner_q      <= REQ_CPU;
      pend_owner_q <= REQ_CPU;
    end else begin
      lock_act_q   <= lock_act_d;
      lock_pend_q  <= lock_pend_d;
      owner_q      <= owner_d;
      pend_owner_q <= pend_owner_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

endmodule

// File: rtl/ppi_arbiter.sv
// Arbitrates CPU and aux access to a PPI register file and generates its write strobe.
// Optional bus locking is compiled in with PPI_ARBITER_LOCK_EN.
module ppi_arbiter
  import ppi_arbiter_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  ppi_arbiter_if.slave cpu,
  ppi_arbiter_if.slave aux,
  output logic [1:0]  ppi_addr,
  output logic        ppi_we_n,
  output logic [7:0]  ppi_idata,
  input  logic [7:0]  ppi_odata,
  output logic        busy,
  output state_e      state_dbg
);

  localparam logic [2:0] STROBE_LAST = 3'(STROBE_CYCLES - 1);

  state_e     state_q, state_d;
  req_id_e    grantee_q, grantee_d;
  logic       acc_we_q, acc_we_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] idata_q, idata_d;
  logic       we_n_q, we_n_d;
  logic       busy_q, busy_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic       aux_ack_q, aux_ack_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] aux_rdata_q, aux_rdata_d;

  logic    grant_valid;
  req_id_e grant_id;

  ppi_arbiter_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk           (clk),
    .reset         (reset),
    .cpu_req_i     (cpu.req),
    .aux_req_i     (aux.req),
`ifdef PPI_ARBITER_LOCK_EN
    .cpu_lock_i    (cpu.lock),
    .aux_lock_i    (aux.lock),
    .done_i        (state_q == ST_ACK),
`endif
    .take_i        (state_q == ST_IDLE),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  always_comb begin
    state_d     = state_q;
    grantee_d   = grantee_q;
    acc_we_d    = acc_we_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    idata_d     = idata_q;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d   = ST_SETUP;
          grantee_d = grant_id;
          if (grant_id == REQ_AUX) begin
            acc_we_d = aux.we;
            addr_d   = aux.addr;
            idata_d  = aux.wdata;
          end else begin
            acc_we_d = cpu.we;
            addr_d   = cpu.addr;
            idata_d  = cpu.wdata;
          end
        end
      end
      ST_SETUP: begin
        state_d = acc_we_q ? ST_STROBE : ST_SAMPLE;
        cnt_d   = '0;
      end
      ST_STROBE: begin
        if (cnt_q == STROBE_LAST) state_d = ST_HOLD;
        else                      cnt_d   = cnt_q + 3'd1;
      end
      ST_HOLD: state_d = ST_ACK;
      ST_SAMPLE: begin
        state_d = ST_ACK;
        if (grantee_q == REQ_AUX) aux_rdata_d = ppi_odata;
        else                      cpu_rdata_d = ppi_odata;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    we_n_d    = (state_d != ST_STROBE);
    busy_d    = (state_d != ST_IDLE);
    cpu_ack_d = (state_d == ST_ACK) && (grantee_d == REQ_CPU);
    aux_ack_d = (state_d == ST_ACK) && (grantee_d == REQ_AUX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grantee_q   <= REQ_CPU;
      acc_we_q    <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= PPI_CTRL;
      idata_q     <= '0;
      we_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      aux_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grantee_q   <= grantee_d;
      acc_we_q    <= acc_we_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      idata_q     <= idata_d;
      we_n_q      <= we_n_d;
      busy_q      <= busy_d;
      cpu_ack_q   <= cpu_ack_d;
      aux_ack_q   <= aux_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  assign ppi_addr  = addr_q;
  assign ppi_we_n  = we_n_q;
  assign ppi_idata = idata_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;
  assign cpu.ack   = cpu_ack_q;
  assign cpu.rdata = cpu_rdata_q;
  assign aux.ack   = aux_ack_q;
  assign aux.rdata = aux_rdata_q;

endmodule

// File: tb/tb_ppi_arbiter.sv
// Directed bench for ppi_arbiter: ack/rdata scoreboard plus bus and latency checks.
module tb_ppi_arbiter;
  import ppi_arbiter_pkg::*;

  localparam int STROBE_CYCLES = 2;
  localparam int STARVE_LIMIT  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] ppi_addr;
  logic       ppi_we_n;
  logic [7:0] ppi_idata;
  logic [7:0] ppi_odata;
  logic       busy;
  state_e     state_dbg;

  ppi_arbiter_if cpu_if ();
  ppi_arbiter_if aux_if ();

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] exp_q[$];
  logic [7:0] ppi_regs[4];
  int         low_cnt = 0;
  int         fall_cnt = 0;
  int         bus_err = 0;
  logic [1:0] bus_addr = 2'd3;
  logic [7:0] bus_data = 8'h00;

  ppi_arbiter #(.STROBE_CYCLES(STROBE_CYCLES), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_if),
    .aux       (aux_if),
    .ppi_addr  (ppi_addr),
    .ppi_we_n  (ppi_we_n),
    .ppi_idata (ppi_idata),
    .ppi_odata (ppi_odata),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // PPI register model: read is combinational, write latches on the falling strobe
  assign ppi_odata = ppi_regs[ppi_addr];
  always @(negedge ppi_we_n) begin
    fall_cnt++;
    ppi_regs[ppi_addr] = ppi_idata;
  end

  always @(negedge clk) begin
    if (!reset && !ppi_we_n) begin
      low_cnt++;
      if (ppi_addr !== bus_addr || ppi_idata !== bus_data) bus_err++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  task automatic sb_pop(input logic id, input logic [7:0] d);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_unexpected_ack: got id=%0d rdata=%02h, required no ack", id, d);
    end else begin
      e = exp_q.pop_front();
      check("sb_ack_id_rdata", {23'b0, id, d}, {23'b0, e});
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_if.ack === 1'b1 && aux_if.ack === 1'b1) begin
        n_tests++;
        n_fail++;
        $display("FAIL dual_ack: got both acks high, required at most one");
      end else if (cpu_if.ack === 1'b1) begin
        sb_pop(1'b0, cpu_if.rdata);
      end else if (aux_if.ack === 1'b1) begin
        sb_pop(1'b1, aux_if.rdata);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic id, input logic r, input logic we,
                       input logic [1:0] a, input logic [7:0] d);
    if (id) begin
      aux_if.req = r; aux_if.we = we; aux_if.addr = a; aux_if.wdata = d;
    end else begin
      cpu_if.req = r; cpu_if.we = we; cpu_if.addr = a; cpu_if.wdata = d;
    end
  endtask

  task automatic do_access(input logic id, input logic we, input logic [1:0] a,
                           input logic [7:0] d, output int lat, output state_e fs);
    @(negedge clk);
    drive(id, 1'b1, we, a, d);
    lat = -1;
    fs  = ST_IDLE;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      if (i == 1) begin
        #1 fs = state_dbg;
      end
      @(negedge clk);
      if ((id ? aux_if.ack : cpu_if.ack) === 1'b1) begin
        lat = i;
        break;
      end
    end
    drive(id, 1'b0, we, a, d);
  endtask

  int     lat, lat2, l0, f0;
  state_e fs, fs2;

  initial begin
    ppi_regs = '{8'h11, 8'h5A, 8'h33, 8'h00};
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
`ifdef PPI_ARBITER_LOCK_EN
    cpu_if.lock = 1'b0;
    aux_if.lock = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_we_n",      32'(ppi_we_n), 32'd1);
    check("rst_addr",      32'(ppi_addr), 32'd3);
    check("rst_idata",     32'(ppi_idata), 32'd0);
    check("rst_cpu_ack",   32'(cpu_if.ack), 32'd0);
    check("rst_aux_ack",   32'(aux_if.ack), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_if.rdata), 32'd0);
    check("rst_aux_rdata", 32'(aux_if.rdata), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_state",     32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);

    // CPU write to control register
    bus_addr = 2'd3; bus_data = 8'h8B;
    l0 = low_cnt; f0 = fall_cnt;
    exp_q.push_back({1'b0, 8'h00});
    do_access(1'b0, 1'b1, 2'd3, 8'h8B, lat, fs);
    check("wr_latency",      32'(lat), 32'd5);
    check("wr_first_state",  32'(fs), 32'(ST_SETUP));
    check("wr_strobe_width", 32'(low_cnt - l0), 32'd2);
    check("wr_fall_edges",   32'(fall_cnt - f0), 32'd1);
    check("wr_bus_stable",   32'(bus_err), 32'd0);

    // CPU read of port B
    l0 = low_cnt; f0 = fall_cnt;
    exp_q.push_back({1'b0, 8'h5A});
    do_access(1'b0, 1'b0, 2'd1, 8'h00, lat, fs);
    check("rd_latency",     32'(lat), 32'd3);
    check("rd_first_state", 32'(fs), 32'(ST_SETUP));
    check("rd_no_strobe",   32'(low_cnt - l0), 32'd0);
    check("rd_no_fall",     32'(fall_cnt - f0), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_addr_hold",  32'(ppi_addr), 32'd1);
    check("idle_we_n",       32'(ppi_we_n), 32'd1);
    check("idle_busy",       32'(busy), 32'd0);
    check("cpu_rdata_held",  32'(cpu_if.rdata), 32'h5A);
    check("aux_rdata_quiet", 32'(aux_if.rdata), 32'd0);

    // simultaneous requests with starve counter at zero: CPU first, then aux
    exp_q.push_back({1'b0, 8'h8B});
    exp_q.push_back({1'b1, 8'h5A});
    fork
      do_access(1'b0, 1'b0, 2'd3, 8'h00, lat, fs);
      do_access(1'b1, 1'b0, 2'd1, 8'h00, lat2, fs2);
    join
    check("both_cpu_latency", 32'(lat), 32'd3);
    check("both_aux_latency", 32'(lat2), 32'd7);
    repeat (2) @(negedge clk);

    // both held continuously: four CPU grants then one aux grant, twice
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < STARVE_LIMIT; c++) exp_q.push_back({1'b0, 8'h11});
      exp_q.push_back({1'b1, 8'h33});
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 8'h00);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
    check("starve_seq_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);

    // reset during the second strobe cycle drops the access
    bus_addr = 2'd0; bus_data = 8'h66;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'd0, 8'h66);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_pre_state", 32'(state_dbg), 32'(ST_STROBE));
    check("midrst_pre_we_n",  32'(ppi_we_n), 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_we_n",    32'(ppi_we_n), 32'd1);
    check("midrst_state",   32'(state_dbg), 32'(ST_IDLE));
    check("midrst_addr",    32'(ppi_addr), 32'd3);
    check("midrst_cpu_ack", 32'(cpu_if.ack), 32'd0);
    check("midrst_busy",    32'(busy), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_idle", 32'(state_dbg), 32'(ST_IDLE));

`ifdef PPI_ARBITER_LOCK_EN
    // aux locks the bus with a write; its next access beats a pending CPU request
    bus_addr = 2'd2; bus_data = 8'h77;
    exp_q.push_back({1'b1, 8'h00});
    aux_if.lock = 1'b1;
    do_access(1'b1, 1'b1, 2'd2, 8'h77, lat, fs);
    aux_if.lock = 1'b0;
    check("lock_wr_latency", 32'(lat), 32'd5);
    exp_q.push_back({1'b1, 8'h77});
    exp_q.push_back({1'b0, 8'h77});
    fork
      do_access(1'b0, 1'b0, 2'd2, 8'h00, lat, fs);
      do_access(1'b1, 1'b0, 2'd2, 8'h00, lat2, fs2);
    join
    check("lock_aux_latency", 32'(lat2), 32'd3);
    check("lock_cpu_latency", 32'(lat), 32'd7);
`endif

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
